// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx byte arbiters: FSM encoding and counter width.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GAP       = 2'd2
  } arb_state_t;

  // Width of the watchdog and inter-byte gap counters.
  localparam int CNT_W = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   g
);

  // Scan from farthest to nearest so the closest set bit after ptr wins.
  always_comb begin
    int idx;
    idx = 0;
    any = 1'b0;
    g   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        any = 1'b1;
        g   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte requesters: round-robin grant, hold until
// done or watchdog expiry, then an optional idle gap before the next grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 2048,
  parameter int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Done,
  output logic [IDX_W-1:0]     o_Grant_Idx,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_REQ - 1);

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_g;
  logic             pick_any;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic             launch;
  logic             finish;
  logic             expire;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (i_Req_Valid),
    .ptr (ptr),
    .any (pick_any),
    .g   (pick_g)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_n;
  end

  // Done takes priority over watchdog expiry in the same cycle.
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    finish  = 1'b0;
    expire  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          launch  = 1'b1;
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_Tx_Done) begin
          finish = 1'b1;
        end else if (wd_cnt == WD_LAST) begin
          finish = 1'b1;
          expire = 1'b1;
        end
        if (finish) state_n = (GAP_CLKS == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if (launch)                  wd_cnt <= '0;
      else if (state == WAIT_DONE) wd_cnt <= wd_cnt + 1'b1;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      ptr         <= '0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= 8'h00;
      o_Req_Ack   <= '0;
      o_Grant_Idx <= '0;
      o_Timeout   <= 1'b0;
    end else begin
      o_Tx_DV   <= launch;
      o_Timeout <= expire;
      o_Req_Ack <= launch ? (NUM_REQ'(1) << pick_g) : '0;
      if (launch) begin
        o_Tx_Byte   <= i_Req_Byte[8*int'(pick_g) +: 8];
        o_Grant_Idx <= pick_g;
        ptr         <= (pick_g == IDX_MAX) ? '0 : pick_g + 1'b1;
      end
    end
  end

  assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a grant-order / timing model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 5;
  localparam int TMO = 2048;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   vld;
  logic [8*N-1:0] bytes;
  logic [N-1:0]   ack;
  logic           dv;
  logic [7:0]     txb;
  logic           done;
  logic [1:0]     gidx;
  logic           busy;
  logic           tmo;

  int errs   = 0;
  int checks = 0;
  int ptr_m  = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .GAP_CLKS     (GAP),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Req_Valid (vld),
    .i_Req_Byte  (bytes),
    .o_Req_Ack   (ack),
    .o_Tx_DV     (dv),
    .o_Tx_Byte   (txb),
    .i_Tx_Done   (done),
    .o_Grant_Idx (gidx),
    .o_Busy      (busy),
    .o_Timeout   (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference grant: first valid requester at or after the model pointer, wrapping.
  function automatic int pick(input logic [N-1:0] m);
    for (int i = 0; i < N; i++)
      if (m[(ptr_m + i) % N]) return (ptr_m + i) % N;
    return 0;
  endfunction

  task automatic ensure_req();
    int k;
    if (vld == '0) begin
      k = $urandom_range(0, N-1);
      bytes[8*k +: 8] = 8'($urandom);
      vld[k] = 1'b1;
    end
  endtask

  // Called with the DUT idle and vld non-zero; the grant must appear after one edge.
  task automatic launch(input string tag, output int g);
    g = pick(vld);
    step();
    chk({tag, "_dv"},   dv,   1);
    chk({tag, "_idx"},  gidx, g);
    chk({tag, "_ack"},  ack,  32'(1) << g);
    chk({tag, "_byte"}, txb,  bytes[8*g +: 8]);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_tmo"},  tmo,  0);
    ptr_m = (g + 1) % N;
  endtask

  // Starts on the first step after the frame ends; GAP busy steps then idle.
  task automatic gap_tail(input string tag, input logic tmo_first);
    for (int i = 0; i < GAP; i++) begin
      chk({tag, "_gbusy"}, busy, 1);
      chk({tag, "_gack"},  ack,  0);
      chk({tag, "_gdv"},   dv,   0);
      chk({tag, "_gtmo"},  tmo,  (i == 0) ? tmo_first : 1'b0);
      done = 1'($urandom_range(0, 1));
      step();
    end
    done = 1'b0;
    chk({tag, "_idle"},   busy, 0);
    chk({tag, "_idledv"}, dv,   0);
  endtask

  task automatic frame(input int len, input logic [7:0] eb, input logic hold, input string tag);
    int k;
    for (int i = 0; i < len; i++) begin
      step();
      chk({tag, "_fbyte"}, txb,  eb);
      chk({tag, "_fdv"},   dv,   0);
      chk({tag, "_fack"},  ack,  0);
      chk({tag, "_fbusy"}, busy, 1);
      chk({tag, "_ftmo"},  tmo,  0);
      if (!hold && $urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, N-1);
        if (!vld[k]) begin
          bytes[8*k +: 8] = 8'($urandom);
          vld[k] = 1'b1;
        end else if ($urandom_range(0, 2) == 0) begin
          vld[k] = 1'b0;
        end
      end
    end
    done = 1'b1;
    step();
    done = 1'b0;
    gap_tail(tag, 1'b0);
  endtask

  initial begin
    int g;
    int n;
    rst   = 1'b0;
    vld   = '0;
    bytes = '0;
    done  = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_dv",   dv,   0);
    chk("rst_byte", txb,  0);
    chk("rst_ack",  ack,  0);
    chk("rst_idx",  gidx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo",  tmo,  0);
    step();
    step();
    rst = 1'b0;

    // Done while idle must not wake the block.
    done = 1'b1;
    step();
    done = 1'b0;
    chk("idle_done_busy", busy, 0);

    // Full contention: all held valid, strict rotation from 0.
    bytes = {8'h13, 8'h12, 8'h11, 8'h10};
    vld   = '1;
    for (int k = 0; k < 6; k++) begin
      launch("rr", g);
      chk("rr_seq",  gidx, k % N);
      chk("rr_byte", txb,  8'h10 + 8'(k % N));
      frame($urandom_range(2, 12), txb, 1'b1, "rr");
    end

    // Pointer now at 2: requesters 3 and 0 must be served as 3 then 0.
    vld = 4'b1001;
    launch("wrap", g);
    chk("wrap_first", gidx, 3);
    vld[3] = 1'b0;
    frame(4, txb, 1'b1, "wrap");
    launch("wrap", g);
    chk("wrap_second", gidx, 0);
    vld[0] = 1'b0;
    frame(4, txb, 1'b1, "wrap");

    // Single request with a full-length frame.
    bytes[23:16] = 8'h41;
    vld = 4'b0100;
    launch("single", g);
    chk("single_byte", txb, 8'h41);
    chk("single_ack",  ack, 4'b0100);
    chk("single_idx",  gidx, 2);
    vld[2] = 1'b0;
    frame(1040, 8'h41, 1'b1, "single");

    // Random traffic with arrivals and withdrawals during frames and gaps.
    for (int it = 0; it < 30; it++) begin
      ensure_req();
      launch("rnd", g);
      vld[g] = 1'b0;
      frame($urandom_range(1, 25), txb, 1'b0, "rnd");
    end

    // Watchdog expiry with no done.
    vld = '0;
    bytes[15:8] = 8'hA5;
    vld[1] = 1'b1;
    launch("wd", g);
    vld[g] = 1'b0;
    n = 0;
    while (n < TMO + 100) begin
      step();
      n++;
      if (tmo) break;
    end
    chk("wd_latency", n, TMO);
    gap_tail("wd", 1'b1);
    ensure_req();
    launch("wd_next", g);
    vld[g] = 1'b0;
    frame(3, txb, 1'b1, "wd_next");

    // Done arriving in the expiry cycle suppresses the timeout.
    ensure_req();
    launch("dw", g);
    vld[g] = 1'b0;
    for (int i = 1; i < TMO; i++) step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("dw_tmo",  tmo,  0);
    chk("dw_busy", busy, 1);
    gap_tail("dw", 1'b0);

    // Asynchronous reset in the middle of a frame.
    vld = '0;
    bytes[15:8] = 8'h5A;
    vld[1] = 1'b1;
    launch("mid", g);
    vld[1] = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_byte", txb,  0);
    chk("mid_idx",  gidx, 0);
    chk("mid_dv",   dv,   0);
    chk("mid_ack",  ack,  0);
    chk("mid_tmo",  tmo,  0);
    step();
    rst   = 1'b0;
    ptr_m = 0;
    vld   = '1;
    launch("post_rst", g);
    chk("post_rst_idx", gidx, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
